// File: rtl/bike_light_multi_fsm.sv
// bike_light_multi_fsm
// Multi-channel bicycle light controller. Each channel has its own mode
// (OFF / ON / BLINK / STROBE) and its own blink rate in beats. The shared
// faster/slower/next buttons edit whichever channel the select button has
// chosen. An internal beat generator paces the BLINK/STROBE phases.
module bike_light_multi_fsm #(
  parameter int NUM_LIGHTS = 2,
  parameter int BEAT_DIV   = 1562500,
  parameter int RATE_W     = 4,
  parameter int RATE_MIN   = 1,
  parameter int RATE_MAX   = 15,
  parameter int RATE_INIT  = 4,
  localparam int SEL_W     = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  faster,
  input  logic                  slower,
  input  logic                  next,
  input  logic                  select,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SEL_W-1:0]      sel_light,
  output logic [1:0]            sel_mode
);

  localparam int BEAT_W = $clog2(BEAT_DIV);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ON     = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_STROBE = 2'd3
  } mode_t;

  logic [BEAT_W-1:0]     beat_cnt_r;
  logic                  tick_s;
  logic [SEL_W-1:0]      sel_r;
  mode_t                 mode_r  [NUM_LIGHTS];
  logic [RATE_W-1:0]     rate_r  [NUM_LIGHTS];
  logic [RATE_W-1:0]     cnt_r   [NUM_LIGHTS];
  logic [NUM_LIGHTS-1:0] phase_r;
  logic [NUM_LIGHTS-1:0] lights_s;
  mode_t                 sel_mode_s;

  // Mode sequence driven by the next button: OFF -> ON -> BLINK -> STROBE -> OFF.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_OFF:    n = MODE_ON;
      MODE_ON:     n = MODE_BLINK;
      MODE_BLINK:  n = MODE_STROBE;
      MODE_STROBE: n = MODE_OFF;
      default:     n = MODE_OFF;
    endcase
    return n;
  endfunction

  // True for the modes whose output follows the phase bit.
  function automatic logic is_flash(input mode_t m);
    return (m == MODE_BLINK) || (m == MODE_STROBE);
  endfunction

  // Count at which the current phase ends. The STROBE lit phase is always a
  // single beat; every other phase lasts rate beats.
  function automatic logic [RATE_W-1:0] term_cnt(input mode_t m, input logic ph,
                                                 input logic [RATE_W-1:0] r);
    logic [RATE_W-1:0] t;
    if ((m == MODE_STROBE) && ph) begin
      t = {RATE_W{1'b0}};
    end else begin
      t = r - RATE_W'(1);
    end
    return t;
  endfunction

  assign tick_s = (beat_cnt_r == BEAT_W'(BEAT_DIV - 1));

  // Free-running beat divider; only reset restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else if (tick_s) begin
      beat_cnt_r <= {BEAT_W{1'b0}};
    end else begin
      beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
    end
  end

  // Channel selection pointer; wraps after the last channel (a single
  // channel design therefore stays at 0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_r <= {SEL_W{1'b0}};
    end else if (select) begin
      if (sel_r == SEL_W'(NUM_LIGHTS - 1)) begin
        sel_r <= {SEL_W{1'b0}};
      end else begin
        sel_r <= sel_r + SEL_W'(1);
      end
    end
  end

  // Per-channel mode FSM, rate register and phase counter. Buttons act on
  // the pre-select channel; a mode entry wins over the same-cycle tick,
  // while the tick (using the old rate) and a rate edit both take effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LIGHTS; i++) begin
        mode_r[i]  <= MODE_OFF;
        rate_r[i]  <= RATE_W'(RATE_INIT);
        cnt_r[i]   <= {RATE_W{1'b0}};
        phase_r[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_LIGHTS; i++) begin
        if ((sel_r == SEL_W'(i)) && next) begin
          mode_r[i]  <= next_mode(mode_r[i]);
          cnt_r[i]   <= {RATE_W{1'b0}};
          phase_r[i] <= is_flash(next_mode(mode_r[i]));
        end else if (tick_s && is_flash(mode_r[i])) begin
          // >= so a rate lowered below the running count ends the phase now.
          if (cnt_r[i] >= term_cnt(mode_r[i], phase_r[i], rate_r[i])) begin
            cnt_r[i]   <= {RATE_W{1'b0}};
            phase_r[i] <= ~phase_r[i];
          end else begin
            cnt_r[i]   <= cnt_r[i] + RATE_W'(1);
          end
        end

        if ((sel_r == SEL_W'(i)) && faster && !slower) begin
          if (rate_r[i] > RATE_W'(RATE_MIN)) begin
            rate_r[i] <= rate_r[i] - RATE_W'(1);
          end
        end else if ((sel_r == SEL_W'(i)) && slower && !faster) begin
          if (rate_r[i] < RATE_W'(RATE_MAX)) begin
            rate_r[i] <= rate_r[i] + RATE_W'(1);
          end
        end
      end
    end
  end

  // Output decode from registered mode and phase only.
  always_comb begin
    lights_s = {NUM_LIGHTS{1'b0}};
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      case (mode_r[i])
        MODE_OFF:    lights_s[i] = 1'b0;
        MODE_ON:     lights_s[i] = 1'b1;
        MODE_BLINK:  lights_s[i] = phase_r[i];
        MODE_STROBE: lights_s[i] = phase_r[i];
        default:     lights_s[i] = 1'b0;
      endcase
    end
  end

  // Mode of the channel currently being edited.
  always_comb begin
    sel_mode_s = mode_r[sel_r];
  end

  assign lights    = lights_s;
  assign sel_light = sel_r;
  assign sel_mode  = sel_mode_s;

endmodule

// File: tb/tb_bike_light_multi_fsm.sv
// Scoreboard bench for bike_light_multi_fsm: the stimulus process updates a
// behavioural model per clock edge and queues the expected outputs; a
// monitor pops and compares one entry after every rising edge.
module tb_bike_light_multi_fsm;

  localparam int NL   = 2;
  localparam int BD   = 4;
  localparam int RMIN = 1;
  localparam int RMAX = 15;
  localparam int RINI = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          faster = 1'b0, slower = 1'b0, next = 1'b0, select = 1'b0;
  logic [NL-1:0] lights;
  logic [0:0]    sel_light;
  logic [1:0]    sel_mode;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q [$];
  logic [4:0] mon_e;

  // Model state: mode 0..3, rate in beats, beats spent in current phase.
  int m_mode [NL];
  int m_rate [NL];
  int m_el   [NL];
  int m_ph   [NL];
  int m_sel;
  int m_cyc;

  bike_light_multi_fsm #(
    .NUM_LIGHTS(NL), .BEAT_DIV(BD), .RATE_W(4),
    .RATE_MIN(RMIN), .RATE_MAX(RMAX), .RATE_INIT(RINI)
  ) dut (
    .clk(clk), .reset(reset), .faster(faster), .slower(slower),
    .next(next), .select(select), .lights(lights),
    .sel_light(sel_light), .sel_mode(sel_mode)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sel = 0;
    m_cyc = 0;
    for (int i = 0; i < NL; i++) begin
      m_mode[i] = 0; m_rate[i] = RINI; m_el[i] = 0; m_ph[i] = 0;
    end
  endtask

  // Advance the model by one rising edge with the given buttons and queue
  // the outputs expected just after that edge.
  task automatic model_edge(input bit f, input bit s, input bit n, input bit sl);
    bit tick;
    int len;
    logic [4:0] e;
    tick = ((m_cyc % BD) == BD - 1);
    m_cyc++;
    for (int i = 0; i < NL; i++) begin
      if (i == m_sel && n) begin
        m_mode[i] = (m_mode[i] + 1) % 4;
        m_el[i]   = 0;
        m_ph[i]   = (m_mode[i] >= 2) ? 1 : 0;
      end else if (tick && m_mode[i] >= 2) begin
        if (m_mode[i] == 2) len = m_rate[i];
        else                len = m_ph[i] ? 1 : m_rate[i];
        m_el[i]++;
        if (m_el[i] >= len) begin
          m_el[i] = 0;
          m_ph[i] = 1 - m_ph[i];
        end
      end
      if (i == m_sel && f && !s && m_rate[i] > RMIN) m_rate[i]--;
      if (i == m_sel && s && !f && m_rate[i] < RMAX) m_rate[i]++;
    end
    if (sl) m_sel = (m_sel + 1) % NL;
    for (int i = 0; i < NL; i++) begin
      e[3+i] = (m_mode[i] == 1) || (m_mode[i] >= 2 && m_ph[i] == 1);
    end
    e[2]   = m_sel[0];
    e[1:0] = m_mode[m_sel][1:0];
    exp_q.push_back(e);
  endtask

  task automatic step(input bit f, input bit s, input bit n, input bit sl);
    @(negedge clk);
    faster = f; slower = s; next = n; select = sl;
    model_edge(f, s, n, sl);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    faster = 1'b0; slower = 1'b0; next = 1'b0; select = 1'b0;
    reset = 1'b1;
    model_reset();
    model_edge(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_now(input string name, input logic [4:0] req);
    n_checks++;
    if ({lights, sel_light, sel_mode} !== req) begin
      n_fail++;
      $display("FAIL %s: got lights=%b sel_light=%0d sel_mode=%0d, want lights=%b sel_light=%0d sel_mode=%0d",
               name, lights, sel_light, sel_mode, req[4:3], req[2], req[1:0]);
    end
  endtask

  // Assert reset between clock edges and check outputs clear with no edge.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_now("async_reset", 5'b00000);
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if ({lights, sel_light, sel_mode} !== mon_e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got lights=%b sel_light=%0d sel_mode=%0d, want lights=%b sel_light=%0d sel_mode=%0d",
                 $time, lights, sel_light, sel_mode, mon_e[4:3], mon_e[2], mon_e[1:0]);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_now("reset_state", 5'b00000);
    release_reset();
    idle(3);
    // Mode cycling on channel 0.
    for (int k = 0; k < 4; k++) begin step(1'b0, 1'b0, 1'b1, 1'b0); idle(10); end
    // BLINK, then rate saturation at both ends.
    step(1'b0, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b1, 1'b0); idle(20);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(40);
    // STROBE at rate 3.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    // Channel 1 to BLINK, then wrap selection.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b1, 1'b0); idle(20);
    step(1'b0, 1'b0, 1'b0, 1'b1); idle(5);
    // Same-cycle combinations.
    step(1'b0, 1'b0, 1'b1, 1'b1); idle(5);
    step(1'b1, 1'b1, 1'b0, 1'b0); idle(5);
    step(1'b0, 1'b1, 1'b1, 1'b0); idle(20);
    // Channel 0 to BLINK then reset mid-operation.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b1, 1'b0); idle(3);
    mid_reset();
    idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b1, 1'b0); idle(20);
    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 23) == 0);
      end
    end
    idle(2);
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
